// File: rtl/mem_ctrl_pkg.sv
// Shared types and parameter defaults for the data-memory controller.
// Holds the FSM state encoding and the word-width / depth / read-latency defaults.
package mem_ctrl_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 10;
    localparam int READ_LAT_DEF = 2;

    // Wide enough for the largest preload value, READ_LAT-1 = 3.
    localparam int CNT_W = 2;

    // ACCESS is the single BRAM strobe cycle that follows acceptance.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/data_mem_ctrl.sv
// Word-aligned load/store bridge from the control unit to a single-port BRAM.
// Write done +2, read +READ_LAT+2, reject +1; new requests are only taken in IDLE, others set overrun.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = READ_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemEn,
    input  logic              MemWen,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy,
    output logic              overrun,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;
    logic                err_q;
    logic                overrun_q;
    logic                bram_en_q;
    logic                bram_we_q;
    logic                addr_ok_d;

    // Word aligned and inside the BRAM's byte range.
    assign addr_ok_d = (addr[1:0] == 2'b00) && ((addr >> (ADDR_W + 2)) == 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            bram_en_q <= 1'b0;
            bram_we_q <= 1'b0;

            if (MemEn && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (MemEn) begin
                        we_q    <= MemWen;
                        waddr_q <= addr[ADDR_W+1:2];
                        wdata_q <= wdata;
                        if (addr_ok_d) begin
                            state_q   <= ACCESS;
                            bram_en_q <= 1'b1;
                            bram_we_q <= MemWen;
                        end else begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= RD_WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        rdata_q <= bram_dout;
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = waddr_q;
    assign bram_din  = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (READ_LAT 2, 1, 4) share stimulus, each with its own BRAM model.
module tb_data_mem_ctrl;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;
    logic        MemEn;
    logic        MemWen;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata     [NDUT];
    logic        mem_ready [NDUT];
    logic        mem_err   [NDUT];
    logic        busy      [NDUT];
    logic        overrun   [NDUT];
    logic        bram_en   [NDUT];
    logic        bram_we   [NDUT];
    logic [9:0]  bram_addr [NDUT];
    logic [31:0] bram_din  [NDUT];
    logic [31:0] bram_dout [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    int lat_r   [NDUT];
    int rdy_cnt [NDUT];
    int err_cnt [NDUT];
    int en_cnt  [NDUT];
    int we_cnt  [NDUT];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic [31:0] mem  [1024];
        logic [31:0] pipe [4];

        data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .READ_LAT(LAT)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .MemEn     (MemEn),
            .MemWen    (MemWen),
            .addr      (addr),
            .wdata     (wdata),
            .rdata     (rdata[g]),
            .mem_ready (mem_ready[g]),
            .mem_err   (mem_err[g]),
            .busy      (busy[g]),
            .overrun   (overrun[g]),
            .bram_en   (bram_en[g]),
            .bram_we   (bram_we[g]),
            .bram_addr (bram_addr[g]),
            .bram_din  (bram_din[g]),
            .bram_dout (bram_dout[g])
        );

        // Read-first BRAM whose output register chain is LAT deep.
        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            end else if (bram_en[g] && bram_we[g]) begin
                mem[bram_addr[g]] <= bram_din[g];
            end
            if (bram_en[g]) pipe[0] <= mem[bram_addr[g]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign bram_dout[g] = pipe[LAT-1];
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // One request pulse, then an 8-sample window; poke_t injects a write request on that sample.
    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] d, input int poke_t);
        MemEn = 1'b1; MemWen = we; addr = a; wdata = d;
        for (int g = 0; g < NDUT; g++) begin
            lat_r[g] = 0; rdy_cnt[g] = 0; err_cnt[g] = 0; en_cnt[g] = 0; we_cnt[g] = 0;
        end
        @(negedge clk);
        MemEn = 1'b0; MemWen = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            for (int g = 0; g < NDUT; g++) begin
                if (bram_en[g]) en_cnt[g]++;
                if (bram_en[g] && bram_we[g]) we_cnt[g]++;
                if (mem_ready[g]) begin
                    rdy_cnt[g]++;
                    if (lat_r[g] == 0) lat_r[g] = t;
                end
                if (mem_err[g]) err_cnt[g]++;
            end
            if (t == poke_t) begin
                MemEn = 1'b1; MemWen = 1'b1; addr = 32'h20; wdata = 32'h1111;
            end else begin
                MemEn = 1'b0; MemWen = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_access(input string tag, input logic we, input logic err, input logic [31:0] exp_rd);
        for (int g = 0; g < NDUT; g++) begin
            check({tag, ".lat"},   g, lat_r[g], err ? 1 : (we ? 2 : lat_of(g) + 2));
            check({tag, ".rdy"},   g, rdy_cnt[g], 1);
            check({tag, ".err"},   g, err_cnt[g], err ? 1 : 0);
            check({tag, ".en"},    g, en_cnt[g], err ? 0 : 1);
            check({tag, ".we"},    g, we_cnt[g], (we && !err) ? 1 : 0);
            check({tag, ".rdata"}, g, rdata[g], exp_rd);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int miss;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 32'h0000_1000, 32'h0BAD,      1'b1, 32'hDEAD_BEEF};
        tbl[5]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hC0DE_00FF};
        tbl[6]  = '{1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'hC0DE_00FF};
        tbl[7]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h1234_5678};
        tbl[8]  = '{1'b1, 32'h0000_0002, 32'h0BAD,      1'b1, 32'h1234_5678};
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hC0DE_0000};
        tbl[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'hC0DE_0000};
        tbl[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hC0DE_03FF};

        reset = 1'b1; mem_init = 1'b1; MemEn = 1'b0; MemWen = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check("rst.rdata",   g, rdata[g], 32'h0);
            check("rst.ready",   g, mem_ready[g], 0);
            check("rst.err",     g, mem_err[g], 0);
            check("rst.busy",    g, busy[g], 0);
            check("rst.overrun", g, overrun[g], 0);
            check("rst.bram_en", g, bram_en[g], 0);
            check("rst.bram_we", g, bram_we[g], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            do_access(tbl[v].we, tbl[v].addr, tbl[v].wdata, 0);
            check_access($sformatf("vec%0d", v), tbl[v].we, tbl[v].err, tbl[v].rdata);
        end

        // MemWen alone must not start anything.
        MemEn = 1'b0; MemWen = 1'b1; addr = 32'h10; wdata = 32'hFFFF;
        repeat (3) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                check("wen_only.busy",    g, busy[g], 0);
                check("wen_only.bram_en", g, bram_en[g], 0);
            end
        end
        MemWen = 1'b0;
        do_access(1'b0, 32'h10, 32'h0, 0);
        check_access("wen_only.rd", 1'b0, 1'b0, 32'hDEAD_BEEF);

        // Request one cycle after acceptance is dropped; overrun is sticky.
        do_access(1'b0, 32'h20, 32'h0, 1);
        check_access("ovr.rd", 1'b0, 1'b0, init_word(8));
        for (int g = 0; g < NDUT; g++) check("ovr.flag", g, overrun[g], 1);
        do_access(1'b0, 32'h20, 32'h0, 0);
        check_access("ovr.rd2", 1'b0, 1'b0, init_word(8));
        for (int g = 0; g < NDUT; g++) check("ovr.sticky", g, overrun[g], 1);

        // Reset while the READ_LAT=2 instance sits in RD_WAIT.
        MemEn = 1'b1; MemWen = 1'b0; addr = 32'h20;
        @(negedge clk);
        MemEn = 1'b0;
        @(negedge clk);
        check("rdwait.busy", 0, busy[0], 1);
        reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("midrd.busy",    g, busy[g], 0);
            check("midrd.ready",   g, mem_ready[g], 0);
            check("midrd.rdata",   g, rdata[g], 32'h0);
            check("midrd.overrun", g, overrun[g], 0);
        end
        reset = 1'b0;
        miss = 0;
        repeat (8) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) if (mem_ready[g]) miss++;
        end
        check("midrd.no_ready", 0, miss, 0);

        // Reset wins over a simultaneous write request.
        reset = 1'b1; MemEn = 1'b1; MemWen = 1'b1; addr = 32'h8; wdata = 32'h55;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("rstreq.bram_we", g, bram_we[g], 0);
            check("rstreq.busy",    g, busy[g], 0);
        end
        reset = 1'b0; MemEn = 1'b0; MemWen = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check("rstreq.bram_we2", g, bram_we[g], 0);
            check("rstreq.busy2",    g, busy[g], 0);
        end
        do_access(1'b0, 32'h8, 32'h0, 0);
        check_access("rstreq.rd", 1'b0, 1'b0, init_word(2));

        // Request landing in the RESP cycle of a write counts as overrun.
        do_access(1'b1, 32'h40, 32'h4040, 2);
        check_access("rspovr.wr", 1'b1, 1'b0, init_word(2));
        for (int g = 0; g < NDUT; g++) check("rspovr.flag", g, overrun[g], 1);
        do_access(1'b0, 32'h40, 32'h0, 0);
        check_access("rspovr.rd40", 1'b0, 1'b0, 32'h4040);
        do_access(1'b0, 32'h20, 32'h0, 0);
        check_access("rspovr.rd20", 1'b0, 1'b0, init_word(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
